dma_input_loader: RTL and testbench

- Prefetch DMA that sits directly downstream of the layer control_unit.
- Services each dma_start by reading a contiguous block of feature-map words from external memory and writing them into one half of the ping-pong input buffer (A=0, B=1).
- Answers with a single-cycle dma_done that the control unit consumes.
- Keeps up to MAX_OUTSTANDING reads in flight so burst memory latency is hidden.

---
 rtl/cnn_dma_pkg.sv | 15 +
 rtl/dma_outstanding_ctr.sv | 18 +
 rtl/dma_input_loader.sv | 85 ++++++++
 tb/tb_dma_input_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_dma_pkg.sv
// cnn_dma_pkg: DMA loader state encoding and ping-pong buffer selects shared with control_unit
package cnn_dma_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } dma_state_e;
  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;
endpackage

// File: rtl/dma_outstanding_ctr.sv
// dma_outstanding_ctr: up/down credit counter of issued-but-unreturned reads with full flag
module dma_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + CW'(inc) - CW'(dec);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign full = cnt_q == CW'(MAX_OUTSTANDING);
endmodule

// File: rtl/dma_input_loader.sv
// dma_input_loader: prefetch DMA copying a contiguous external block into one ping-pong buffer half
module dma_input_loader
  import cnn_dma_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MEM_AW          = 24,
  parameter int BUF_AW          = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_start,
  input  logic [MEM_AW-1:0] src_base,
  input  logic [BUF_AW:0]   xfer_len,
  input  logic              dst_buf,
  output logic              dma_done,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [MEM_AW-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              buf_wr_en,
  output logic              buf_wr_sel,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data
);
  localparam int LW = BUF_AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(1) << BUF_AW;
  dma_state_e state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d, issued_q, issued_d, rcvd_q, rcvd_d;
  logic sel_q, sel_d, full, req_fire, rsp_fire;
  dma_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr (
    .clk(clk), .reset(reset), .inc(req_fire), .dec(rsp_fire), .full(full)
  );
  always_comb begin
    mem_req_valid = state_q == ISSUE && issued_q < len_q && !full;
    req_fire = mem_req_valid && mem_req_ready;
    rsp_fire = mem_rsp_valid && (state_q == ISSUE || state_q == DRAIN);
    issued_d = issued_q + LW'(req_fire);
    rcvd_d = rcvd_q + LW'(rsp_fire);
    addr_d = addr_q + MEM_AW'(req_fire);
    len_d = len_q;
    sel_d = sel_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (dma_start) begin
        len_d = xfer_len > MAX_LEN ? MAX_LEN : xfer_len;
        addr_d = src_base;
        sel_d = dst_buf;
        issued_d = '0;
        rcvd_d = '0;
        state_d = xfer_len == '0 ? DONE : ISSUE;
      end
      // a same-cycle response to the last request may already complete the block
      ISSUE: if (req_fire && issued_d == len_q) state_d = rcvd_d == len_q ? DONE : DRAIN;
      DRAIN: if (rcvd_d == len_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      issued_q <= '0;
      rcvd_q <= '0;
      sel_q <= BUF_A;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      issued_q <= issued_d;
      rcvd_q <= rcvd_d;
      sel_q <= sel_d;
    end
  assign busy = state_q != IDLE;
  assign dma_done = state_q == DONE;
  assign mem_req_addr = addr_q;
  assign buf_wr_en = rsp_fire;
  assign buf_wr_sel = sel_q;
  assign buf_wr_addr = rcvd_q[BUF_AW-1:0];
  assign buf_wr_data = rsp_fire ? mem_rsp_data : '0;
endmodule

// File: tb/tb_dma_input_loader.sv
// tb_dma_input_loader: randomized scenarios against a queue-based memory and transfer model
module tb_dma_input_loader;
  localparam int DW = 32, AW = 24, BW = 10, MO = 4, LW = BW + 1;
  logic clk = 0, reset = 1, dma_start = 0, dst_buf = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0;
  logic [AW-1:0] src_base = '0;
  logic [LW-1:0] xfer_len = '0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic dma_done, busy, mem_req_valid, buf_wr_en, buf_wr_sel;
  logic [AW-1:0] mem_req_addr;
  logic [BW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;

  dma_input_loader #(.DATA_W(DW), .MEM_AW(AW), .BUF_AW(BW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset), .dma_start(dma_start), .src_base(src_base), .xfer_len(xfer_len),
    .dst_buf(dst_buf), .dma_done(dma_done), .busy(busy), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0, start_cyc = 0;
  int lat = 1, rdy_mode = 0, done_cnt = 0, done_cyc = 0, max_out = 0, hold_errs = 0;
  logic force_rsp = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] salt;
  typedef struct {int due; logic [AW-1:0] addr;} pend_t;
  pend_t pend[$];
  logic [AW-1:0] reqs[$], exp_r[$];
  int req_cyc[$];
  logic [BW+DW:0] wrs[$], exp_w[$];

  function automatic logic [DW-1:0] data_of(logic [AW-1:0] a);
    return ({8'h00, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  // memory: in-order responses after lat cycles, ready pattern by mode
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      pend.delete();
      mem_rsp_valid = 0;
      mem_rsp_data = '0;
      mem_req_ready = 0;
    end else begin
      mem_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      mem_rsp_valid = force_rsp;
      mem_rsp_data = force_rsp ? $urandom : '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1;
        mem_rsp_data = data_of(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      reqs.push_back(mem_req_addr);
      req_cyc.push_back(cyc);
      pend.push_back('{cyc + lat, mem_req_addr});
    end
    if (!reset && prev_stall && !(mem_req_valid && mem_req_addr == prev_addr)) hold_errs++;
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    if (buf_wr_en) wrs.push_back({buf_wr_sel, buf_wr_addr, buf_wr_data});
    if (reqs.size() - wrs.size() > max_out) max_out = reqs.size() - wrs.size();
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_rec;
    reqs.delete(); req_cyc.delete(); wrs.delete();
    done_cnt = 0; max_out = 0; hold_errs = 0;
  endtask

  // expected transfer: clamped length, wrapped word addresses, buffer address = word index
  task automatic build_model(input logic [AW-1:0] b, input int l, input logic s);
    exp_r.delete(); exp_w.delete();
    if (l > (1 << BW)) l = 1 << BW;
    for (int i = 0; i < l; i++) begin
      exp_r.push_back(AW'(b + i));
      exp_w.push_back({s, BW'(i), data_of(AW'(b + i))});
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic s);
    @(posedge clk); #2;
    clear_rec();
    src_base = b; xfer_len = l; dst_buf = s; dma_start = 1; start_cyc = cyc;
    @(posedge clk); #2;
    dma_start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if ({busy, dma_done, mem_req_valid, mem_req_addr, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b rv=%b wr=%b want all 0", busy, dma_done, mem_req_valid, buf_wr_en);
    end
    reset = 0;
  endtask

  task automatic test_basic;
    int bad;
    lat = 1; rdy_mode = 0;
    start_xfer(24'h100, 4, 1);
    wait_done(100);
    build_model(24'h100, 4, 1);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL basic_data: %0d reqs %0d writes %0d bad, want 4/4/0", reqs.size(), wrs.size(), bad); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    vectors++;
    if (req_cyc.size() != 4 || req_cyc[3] - req_cyc[0] != 3) begin miscompares++; $display("FAIL basic_back_to_back: %0d reqs, want 4 on consecutive cycles", req_cyc.size()); end
    vectors++;
    if (req_cyc.size() == 4 && done_cyc - req_cyc[3] != 2) begin miscompares++; $display("FAIL basic_done_latency: got %0d want 2", done_cyc - req_cyc[3]); end
  endtask

  task automatic test_throttle;
    int bad;
    lat = 10; rdy_mode = 0;
    start_xfer(24'h2000, 8, 0);
    wait_done(300);
    build_model(24'h2000, 8, 0);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL throttle_data: %0d reqs %0d writes %0d bad, want 8/8/0", reqs.size(), wrs.size(), bad); end
    vectors++;
    if (max_out != MO) begin miscompares++; $display("FAIL throttle_outstanding: peak %0d want %0d", max_out, MO); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL throttle_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_ready_stall;
    int bad;
    lat = 2; rdy_mode = 1;
    start_xfer(24'h3456, 3, 1);
    wait_done(200);
    build_model(24'h3456, 3, 1);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL stall_data: %0d reqs %0d writes %0d bad, want 3/3/0", reqs.size(), wrs.size(), bad); end
    vectors++;
    if (hold_errs != 0) begin miscompares++; $display("FAIL stall_hold: %0d unstable cycles want 0", hold_errs); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
    rdy_mode = 0;
  endtask

  task automatic test_len0;
    lat = 1;
    start_xfer(24'h55, 0, 0);
    wait_done(20);
    vectors++;
    if (reqs.size() != 0 || wrs.size() != 0) begin miscompares++; $display("FAIL len0_traffic: %0d reqs %0d writes want 0/0", reqs.size(), wrs.size()); end
    vectors++;
    if (done_cnt != 1 || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      miscompares++; $display("FAIL len0_done: count %0d latency %0d want 1 within 1..2", done_cnt, done_cyc - start_cyc);
    end
    force_rsp = 1;
    repeat (3) @(posedge clk);
    force_rsp = 0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (wrs.size() != 0) begin miscompares++; $display("FAIL idle_rsp_write: got %0d writes want 0", wrs.size()); end
  endtask

  task automatic test_busy_start;
    logic [AW-1:0] b0, b1;
    int bad;
    b0 = AW'($urandom); b1 = b0 + 24'h40; lat = 3; rdy_mode = 0;
    start_xfer(b0, 8, 0);
    repeat (3) @(posedge clk);
    #2;
    src_base = b1; xfer_len = 5; dst_buf = 1; dma_start = 1;
    @(posedge clk); #2;
    dma_start = 0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin @(posedge clk); #2; end
    build_model(b0, 8, 0);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0 || done_cnt != 1) begin miscompares++; $display("FAIL busy_ignore: %0d reqs %0d bad %0d dones, want 8/0/1", reqs.size(), bad, done_cnt); end
    clear_rec();
    src_base = b1; xfer_len = 5; dst_buf = 1; dma_start = 1;
    @(posedge clk); #2;
    dma_start = 0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_accept: busy %b want 1", busy); end
    wait_done(200);
    build_model(b1, 5, 1);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0 || done_cnt != 1) begin miscompares++; $display("FAIL restart_data: %0d reqs %0d bad %0d dones, want 5/0/1", reqs.size(), bad, done_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] b;
    int bad;
    lat = 1; rdy_mode = 0;
    start_xfer(24'h7000, 6, 1);
    for (int i = 0; i < 100 && wrs.size() < 2; i++) begin @(posedge clk); #2; end
    reset = 1;
    #1;
    vectors++;
    if ({busy, dma_done, mem_req_valid, mem_req_addr, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy=%b rv=%b addr=%h wr=%b want all 0", busy, mem_req_valid, mem_req_addr, buf_wr_en);
    end
    repeat (2) @(posedge clk);
    #3;
    reset = 0;
    repeat (4) @(posedge clk);
    #2;
    vectors++;
    if (done_cnt != 0 || wrs.size() != 2) begin miscompares++; $display("FAIL midreset_abort: %0d dones %0d writes want 0/2", done_cnt, wrs.size()); end
    b = AW'($urandom);
    start_xfer(b, 2, 0);
    wait_done(100);
    build_model(b, 2, 0);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0 || done_cnt != 1) begin miscompares++; $display("FAIL midreset_fresh: %0d reqs %0d bad %0d dones, want 2/0/1", reqs.size(), bad, done_cnt); end
  endtask

  task automatic test_clamp_wrap;
    int bad;
    lat = 2; rdy_mode = 0;
    start_xfer(24'hFF_FFFD, 11'h7FF, 1);
    wait_done(3000);
    build_model(24'hFF_FFFD, 11'h7FF, 1);
    bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
    foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL clamp_wrap_data: %0d reqs %0d writes %0d bad, want 1024/1024/0", reqs.size(), wrs.size(), bad); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL clamp_wrap_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random;
    logic [AW-1:0] b;
    logic s;
    int l, bad;
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 6); rdy_mode = $urandom_range(0, 2);
      l = $urandom_range(1, 40); b = AW'($urandom); s = 1'($urandom_range(0, 1));
      start_xfer(b, LW'(l), s);
      wait_done(2000);
      build_model(b, l, s);
      bad = int'(reqs.size() != exp_r.size()) + int'(wrs.size() != exp_w.size());
      foreach (exp_r[i]) bad += int'(i < reqs.size() && reqs[i] !== exp_r[i]) + int'(i < wrs.size() && wrs[i] !== exp_w[i]);
      vectors++;
      if (bad != 0 || done_cnt != 1) begin
        miscompares++; $display("FAIL random%0d_xfer: len %0d got %0d reqs %0d bad %0d dones, want 0 bad 1 done", n, l, reqs.size(), bad, done_cnt);
      end
      vectors++;
      if (max_out > MO || hold_errs != 0) begin
        miscompares++; $display("FAIL random%0d_flow: peak %0d hold_errs %0d want <=%0d and 0", n, max_out, hold_errs, MO);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_basic();
    test_throttle();
    test_ready_stall();
    test_len0();
    test_busy_start();
    test_reset_mid();
    test_clamp_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
